// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command bytes and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_REQ     = 3'd2,
    ST_BITS    = 3'd3,
    ST_ACK     = 3'd4,
    ST_ABORT   = 3'd5
  } state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;

  // PS/2 frames carry odd parity: the nine data+parity bits hold an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 line conditioning: 2-flop synchronisers, falling-edge detect on the clock line,
// and an optional clock glitch filter enabled by defining PS2_FILTER_EN.
module ps2_line_sync #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic data_o,
  output logic fall_o
);

  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       clk_lvl;
  logic       clk_prev_q;

  // Idle PS/2 lines float high, so the synchronisers reset to 1 to avoid a false fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
    end
  end

`ifdef PS2_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN + 1);
  logic           filt_q;
  logic [FCW-1:0] fcnt_q;

  // The filtered level flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else if (clk_sync_q[1] == filt_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
      filt_q <= clk_sync_q[1];
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + FCW'(1);
    end
  end

  assign clk_lvl = filt_q;
`else
  assign clk_lvl = clk_sync_q[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clk_prev_q <= 1'b1;
    else        clk_prev_q <= clk_lvl;
  end

  assign fall_o = clk_prev_q & ~clk_lvl;
  assign data_o = data_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-drain line enables.
// Build option: PS2_FILTER_EN adds a glitch filter on the sampled PS/2 clock.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC  = 5000,
  parameter int START_TO_CYC = 750000,
  parameter int PKT_TO_CYC   = 100000,
  parameter int FILTER_LEN   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output state_e     dbg_state_o
);

  localparam int MAX_A = (START_TO_CYC > PKT_TO_CYC) ? START_TO_CYC : PKT_TO_CYC;
  localparam int MAX_C = (MAX_A > INHIBIT_CYC) ? MAX_A : INHIBIT_CYC;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYC - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_TO_CYC - 1);
  localparam logic [CW-1:0] PKT_LAST   = CW'(PKT_TO_CYC - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    bitcnt_q;
  logic [8:0]    shreg_q;
  logic          clk_oe_q, data_oe_q;
  logic          done_q, ack_err_q, timeout_q;
  logic          data_s, fall_s;

  ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .data_o     (data_s),
    .fall_o     (fall_s)
  );

  // Handshake: a command is accepted on a clock edge where tx_valid && tx_ready; the
  // source holds tx_valid and tx_data stable until then, and tx_ready is high only in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tx_valid) begin
            shreg_q  <= {odd_parity(tx_data), tx_data};
            cnt_q    <= '0;
            clk_oe_q <= 1'b1;
            data_oe_q <= 1'b0;
            state_q  <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (cnt_q == INH_LAST) begin
            cnt_q     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b1;
            state_q   <= ST_REQ;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_REQ: begin
          if (fall_s) begin
            data_oe_q <= ~shreg_q[0];
            shreg_q   <= shreg_q >> 1;
            bitcnt_q  <= 4'd1;
            cnt_q     <= '0;
            state_q   <= ST_BITS;
          end else if (cnt_q == START_LAST) begin
            data_oe_q <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= ST_ABORT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_BITS: begin
          if (cnt_q == PKT_LAST) begin
            data_oe_q <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= ST_ABORT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (fall_s) begin
              bitcnt_q <= bitcnt_q + 4'd1;
              // Fall 10 releases data for the stop bit; earlier falls shift out bit1..parity.
              if (bitcnt_q == 4'd9) begin
                data_oe_q <= 1'b0;
                state_q   <= ST_ACK;
              end else begin
                data_oe_q <= ~shreg_q[0];
                shreg_q   <= shreg_q >> 1;
              end
            end
          end
        end
        ST_ACK: begin
          if (done_q || ack_err_q) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == PKT_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= ST_ABORT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (fall_s) begin
              done_q    <= ~data_s;
              ack_err_q <= data_s;
            end
          end
        end
        ST_ABORT: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign ack_err     = ack_err_q;
  assign timeout     = timeout_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed and randomized bench for ps2_host_tx with a behavioural PS/2 keyboard model.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, ack_err, timeout;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  wire logic  ps2_clk_i;
  wire logic  ps2_data_i;
  state_e     dbg_state;

  int total = 0;
  int bad = 0;
  int done_cnt = 0, ackerr_cnt = 0, to_cnt = 0, overlap_cnt = 0;
  logic [9:0] exp_q[$];

  // Wired-AND open-drain bus: either side may pull a line low.
  assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_i = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYC(20), .START_TO_CYC(200), .PKT_TO_CYC(400)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .ack_err     (ack_err),
    .timeout     (timeout),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (ack_err) ackerr_cnt++;
    if (timeout) to_cnt++;
    if (int'(done) + int'(ack_err) + int'(timeout) > 1) overlap_cnt++;
  end

  // ---------------- reference model ----------------
  // Frame as seen by the device on rising edges: 8 data bits LSB first, odd parity, stop=1.
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Offers a byte, then follows the inhibit phase up to the first negedge of the request phase.
  task automatic send(input logic [7:0] b, input bit hold, input logic [7:0] nb);
    int n;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 1000) begin @(negedge clk); n++; end
    check("ready_wait", 32'(n < 1000), 32'd1);
    @(negedge clk);
    if (hold) tx_data = nb;
    else      tx_valid = 1'b0;
    check("accept_latency", {29'd0, ps2_clk_oe, ps2_data_oe, busy}, 32'b101);
    n = 1;
    while (ps2_clk_oe && n < 100) begin @(negedge clk); n++; end
    check("inhibit_len", n, 32'd21);
    check("start_bit", ps2_data_oe, 32'd1);
  endtask

  // Keyboard model: 11 clock pulses of 10-cycle half period; samples data before each rise.
  task automatic dev_frame(input bit ack_low, input int rst_fall, output logic [9:0] got);
    got = '0;
    repeat (3 + $urandom_range(0, 5)) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      dev_clk = 1'b0;
      if (k == rst_fall) begin
        rst_n = 1'b0;
        #1;
        check("rst_clk_oe", ps2_clk_oe, 32'd0);
        check("rst_data_oe", ps2_data_oe, 32'd0);
        return;
      end
      repeat (10) @(negedge clk);
      if (k <= 10) got[k-1] = ps2_data_i;
      dev_clk = 1'b1;
      if (k == 10 && ack_low) dev_data = 1'b0;
      repeat (10) @(negedge clk);
      if (k == 11) dev_data = 1'b1;
    end
  endtask

  task automatic frame_check(input string tag, input logic [7:0] b, input bit ack_low);
    logic [9:0] got;
    int d0, a0;
    d0 = done_cnt;
    a0 = ackerr_cnt;
    exp_q.push_back(model_frame(b));
    dev_frame(ack_low, 0, got);
    check({tag, "_bits"}, got, exp_q.pop_front());
    check({tag, "_done"}, done_cnt - d0, ack_low ? 32'd1 : 32'd0);
    check({tag, "_ackerr"}, ackerr_cnt - a0, ack_low ? 32'd0 : 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_idle"}, {30'd0, tx_ready, busy}, 32'b10);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] got;
    logic [7:0] b;
    int n, t0;
    bit ack;

    repeat (3) @(negedge clk);
    check("reset_outs", {26'd0, tx_ready, busy, done, ack_err, timeout, ps2_clk_oe},
          32'b100000);
    check("reset_data_oe", ps2_data_oe, 32'd0);
    check("reset_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // set-LEDs command, acknowledged
    send(CMD_SET_LEDS, 1'b0, 8'h00);
    exp_q.push_back(model_frame(CMD_SET_LEDS));
    dev_frame(1'b1, 0, got);
    check("ed_bits", got, exp_q.pop_front());
    check("ed_parity", got[8], 32'd1);
    check("ed_done", done_cnt, 32'd1);
    check_idle("ed");

    // parity extremes
    send(8'h01, 1'b0, 8'h00);
    exp_q.push_back(model_frame(8'h01));
    dev_frame(1'b1, 0, got);
    check("p01_bits", got, exp_q.pop_front());
    check("p01_parity", got[8], 32'd0);
    send(CMD_RESET, 1'b0, 8'h00);
    frame_check("pff", CMD_RESET, 1'b1);
    check_idle("pff");

    // device never clocks
    send(CMD_ENABLE, 1'b0, 8'h00);
    t0 = to_cnt;
    n = 0;
    while (!timeout && n < 400) begin @(negedge clk); n++; end
    check("to_delay", n, 32'd200);
    check("to_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("to_ready_during", tx_ready, 32'd0);
    @(negedge clk);
    check("to_pulse_cnt", to_cnt - t0, 32'd1);
    check_idle("to");

    // no ACK from device
    send(8'hA5, 1'b0, 8'h00);
    frame_check("noack", 8'hA5, 1'b0);
    check_idle("noack");

    // reset in the middle of a frame
    send(CMD_SET_LEDS, 1'b0, 8'h00);
    dev_frame(1'b1, 5, got);
    repeat (3) @(negedge clk);
    check_idle("rst_mid");
    check("rst_mid_state", dbg_state, ST_IDLE);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(CMD_ENABLE, 1'b0, 8'h00);
    frame_check("after_rst", CMD_ENABLE, 1'b1);

    // request held during a busy frame is taken only afterwards
    send(CMD_SET_LEDS, 1'b1, 8'h55);
    frame_check("hold_ed", CMD_SET_LEDS, 1'b1);
    n = 0;
    while (!(ps2_data_oe && !ps2_clk_oe) && n < 100) begin @(negedge clk); n++; end
    check("hold_req_seen", 32'(n < 100), 32'd1);
    tx_valid = 1'b0;
    frame_check("hold_55", 8'h55, 1'b1);
    check_idle("hold");

    // randomized commands and ACK behaviour
    for (int i = 0; i < 5; i++) begin
      b   = 8'($urandom_range(0, 255));
      ack = ($urandom_range(0, 3) != 0);
      send(b, 1'b0, 8'h00);
      frame_check("rand", b, ack);
      check_idle("rand");
    end

    check("pulse_overlap", overlap_cnt, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
